// File: rtl/codec_cfg_pkg.sv
`default_nettype none
// ============================================================================
// Package     : codec_cfg_pkg
// Description : Shared types and the register table for the codec setup
//               sequencer.
// Revision    : 1.0 - initial release
// ============================================================================
package codec_cfg_pkg;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        START = 3'd1,
        BYTE  = 3'd2,
        ACK   = 3'd3,
        STOP  = 3'd4,
        GAP   = 3'd5,
        FIN   = 3'd6,
        ERR   = 3'd7
    } cfg_state_t;

    typedef struct packed {
        logic [6:0] reg_addr;
        logic [8:0] data;
    } cfg_entry_t;

    localparam int N_REGS = 10;

    // The activation word (index 10) only goes out when N_REGS is raised to 11.
    function automatic cfg_entry_t cfg_entry(input logic [3:0] idx);
        cfg_entry_t e;
        case (idx)
            4'd0:    e = {7'h0F, 9'h000};
            4'd1:    e = {7'h00, 9'h017};
            4'd2:    e = {7'h01, 9'h017};
            4'd3:    e = {7'h02, 9'h079};
            4'd4:    e = {7'h03, 9'h079};
            4'd5:    e = {7'h04, 9'h012};
            4'd6:    e = {7'h05, 9'h000};
            4'd7:    e = {7'h06, 9'h000};
            4'd8:    e = {7'h07, 9'h042};
            4'd9:    e = {7'h08, 9'h000};
            4'd10:   e = {7'h09, 9'h001};
            default: e = '0;
        endcase
        return e;
    endfunction

endpackage
`default_nettype wire

// File: rtl/i2c_tick_gen.sv
`default_nettype none
// ============================================================================
// Module      : i2c_tick_gen
// Description : Quarter-period divider; one-cycle tick every CLK_DIV clocks
//               while enabled, counter parked at zero otherwise.
// Revision    : 1.0 - initial release
// ============================================================================
module i2c_tick_gen #(
    parameter int CLK_DIV = 125
) (
    input  logic clk,
    input  logic reset,
    input  logic enable,
    output logic tick
);

    localparam int C_CW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

    logic [C_CW-1:0] r_cnt;
    logic            w_wrap;

    assign w_wrap = (r_cnt == C_CW'(CLK_DIV - 1));
    assign tick   = enable && w_wrap;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_cnt <= '0;
        end else if (!enable || w_wrap) begin
            r_cnt <= '0;
        end else begin
            r_cnt <= r_cnt + C_CW'(1);
        end
    end

endmodule
`default_nettype wire

// File: rtl/codec_config_seq.sv
`default_nettype none
// ============================================================================
// Module      : codec_config_seq
// Description : Writes the codec register table over I2C (open-drain
//               enables), one START/3 bytes/STOP transaction per entry.
// Revision    : 1.0 - initial release
// ============================================================================
module codec_config_seq #(
    parameter int         CLK_DIV  = 125,
    parameter logic [6:0] DEV_ADDR = 7'h1A,
    parameter int         N_REGS   = codec_cfg_pkg::N_REGS
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       start,
    output logic       busy,
    output logic       done,
    output logic       error,
    output logic [3:0] err_idx,
    output logic       scl_oe,
    output logic       sda_oe,
    input  logic       sda_i
);

    import codec_cfg_pkg::*;

    cfg_state_t r_state, w_state_nxt;
    logic       r_busy, r_done, r_error, r_scl_oe, r_sda_oe, r_nack;
    logic       w_busy_nxt, w_done_nxt, w_error_nxt, w_scl_nxt, w_sda_nxt, w_nack_nxt;
    logic [3:0] r_err_idx, r_idx, w_err_idx_nxt, w_idx_nxt;
    logic [1:0] r_byte_cnt, r_q, w_byte_cnt_nxt, w_q_nxt;
    logic [2:0] r_bit_cnt, r_cnt, w_bit_cnt_nxt, w_cnt_nxt;
    logic [7:0] r_shift, w_shift_nxt;
    cfg_entry_t w_entry;
    logic       w_tick;

    i2c_tick_gen #(.CLK_DIV(CLK_DIV)) u_tick (
        .clk    (clk),
        .reset  (reset),
        .enable (r_busy),
        .tick   (w_tick)
    );

    assign w_entry = cfg_entry(r_idx);

    // Line enables only move on a tick, so each quarter is glitch-free.
    always_comb begin
        w_state_nxt    = r_state;
        w_busy_nxt     = r_busy;
        w_done_nxt     = r_done;
        w_error_nxt    = r_error;
        w_err_idx_nxt  = r_err_idx;
        w_scl_nxt      = r_scl_oe;
        w_sda_nxt      = r_sda_oe;
        w_idx_nxt      = r_idx;
        w_byte_cnt_nxt = r_byte_cnt;
        w_bit_cnt_nxt  = r_bit_cnt;
        w_q_nxt        = r_q;
        w_cnt_nxt      = r_cnt;
        w_shift_nxt    = r_shift;
        w_nack_nxt     = r_nack;
        case (r_state)
            IDLE: begin
                if (start) begin
                    w_state_nxt   = START;
                    w_busy_nxt    = 1'b1;
                    w_done_nxt    = 1'b0;
                    w_error_nxt   = 1'b0;
                    w_err_idx_nxt = 4'd0;
                    w_idx_nxt     = 4'd0;
                    w_cnt_nxt     = 3'd0;
                    w_nack_nxt    = 1'b0;
                end
            end
            START: begin
                if (w_tick) begin
                    if (r_cnt == 3'd0) begin
                        w_sda_nxt = 1'b1;
                        w_cnt_nxt = 3'd1;
                    end else if (r_cnt == 3'd1) begin
                        w_cnt_nxt = 3'd2;
                    end else begin
                        w_scl_nxt      = 1'b1;
                        w_cnt_nxt      = 3'd0;
                        w_q_nxt        = 2'd0;
                        w_bit_cnt_nxt  = 3'd7;
                        w_byte_cnt_nxt = 2'd0;
                        w_shift_nxt    = {DEV_ADDR, 1'b0};
                        w_state_nxt    = BYTE;
                    end
                end
            end
            BYTE: begin
                if (w_tick) begin
                    case (r_q)
                        2'd0: begin
                            w_scl_nxt = 1'b1;
                            w_sda_nxt = ~r_shift[7];
                            w_q_nxt   = 2'd1;
                        end
                        2'd1: w_q_nxt = 2'd2;
                        2'd2: begin
                            w_scl_nxt = 1'b0;
                            w_q_nxt   = 2'd3;
                        end
                        2'd3: begin
                            w_q_nxt     = 2'd0;
                            w_shift_nxt = {r_shift[6:0], 1'b0};
                            if (r_bit_cnt == 3'd0) begin
                                w_state_nxt = ACK;
                            end else begin
                                w_bit_cnt_nxt = r_bit_cnt - 3'd1;
                            end
                        end
                    endcase
                end
            end
            ACK: begin
                if (w_tick) begin
                    case (r_q)
                        2'd0: begin
                            w_scl_nxt = 1'b1;
                            w_sda_nxt = 1'b0;
                            w_q_nxt   = 2'd1;
                        end
                        2'd1: w_q_nxt = 2'd2;
                        2'd2: begin
                            w_scl_nxt = 1'b0;
                            w_q_nxt   = 2'd3;
                            if (sda_i) begin
                                w_nack_nxt    = 1'b1;
                                w_err_idx_nxt = r_idx;
                            end
                        end
                        2'd3: begin
                            w_q_nxt = 2'd0;
                            if (r_nack || (r_byte_cnt == 2'd2)) begin
                                w_cnt_nxt   = 3'd0;
                                w_state_nxt = STOP;
                            end else begin
                                w_byte_cnt_nxt = r_byte_cnt + 2'd1;
                                w_bit_cnt_nxt  = 3'd7;
                                w_shift_nxt    = (r_byte_cnt == 2'd0) ?
                                                 {w_entry.reg_addr, w_entry.data[8]} :
                                                 w_entry.data[7:0];
                                w_state_nxt    = BYTE;
                            end
                        end
                    endcase
                end
            end
            STOP: begin
                if (w_tick) begin
                    if (r_cnt == 3'd0) begin
                        w_scl_nxt = 1'b1;
                        w_sda_nxt = 1'b1;
                        w_cnt_nxt = 3'd1;
                    end else if (r_cnt == 3'd1) begin
                        w_scl_nxt = 1'b0;
                        w_cnt_nxt = 3'd2;
                    end else begin
                        w_sda_nxt = 1'b0;
                        w_cnt_nxt = 3'd0;
                        if (r_nack) begin
                            w_state_nxt = ERR;
                        end else if (r_idx == 4'(N_REGS - 1)) begin
                            w_state_nxt = FIN;
                        end else begin
                            w_state_nxt = GAP;
                        end
                    end
                end
            end
            GAP: begin
                if (w_tick) begin
                    if (r_cnt == 3'd7) begin
                        w_cnt_nxt   = 3'd0;
                        w_idx_nxt   = r_idx + 4'd1;
                        w_state_nxt = START;
                    end else begin
                        w_cnt_nxt = r_cnt + 3'd1;
                    end
                end
            end
            FIN: begin
                w_done_nxt  = 1'b1;
                w_busy_nxt  = 1'b0;
                w_state_nxt = IDLE;
            end
            ERR: begin
                w_error_nxt = 1'b1;
                w_busy_nxt  = 1'b0;
                w_state_nxt = IDLE;
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state    <= IDLE;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
            r_error    <= 1'b0;
            r_err_idx  <= 4'd0;
            r_scl_oe   <= 1'b0;
            r_sda_oe   <= 1'b0;
            r_idx      <= 4'd0;
            r_byte_cnt <= 2'd0;
            r_bit_cnt  <= 3'd0;
            r_q        <= 2'd0;
            r_cnt      <= 3'd0;
            r_shift    <= 8'd0;
            r_nack     <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_busy     <= w_busy_nxt;
            r_done     <= w_done_nxt;
            r_error    <= w_error_nxt;
            r_err_idx  <= w_err_idx_nxt;
            r_scl_oe   <= w_scl_nxt;
            r_sda_oe   <= w_sda_nxt;
            r_idx      <= w_idx_nxt;
            r_byte_cnt <= w_byte_cnt_nxt;
            r_bit_cnt  <= w_bit_cnt_nxt;
            r_q        <= w_q_nxt;
            r_cnt      <= w_cnt_nxt;
            r_shift    <= w_shift_nxt;
            r_nack     <= w_nack_nxt;
        end
    end

    assign busy    = r_busy;
    assign done    = r_done;
    assign error   = r_error;
    assign err_idx = r_err_idx;
    assign scl_oe  = r_scl_oe;
    assign sda_oe  = r_sda_oe;

endmodule
`default_nettype wire
